// File: rtl/morse_sequence_storage_pkg.sv
// Shared constants and types for the Morse sequence storage block.
// Symbol codes match those used by the downstream translator.
package morse_sequence_storage_pkg;

  localparam int NUM_CHARS    = 3;
  localparam int SYMS_PER_CHR = 5;
  localparam int CHAR_W       = 2 * SYMS_PER_CHR;
  localparam int SEQ_W        = NUM_CHARS * CHAR_W;
  localparam int SYM_CNT_W    = $clog2(SYMS_PER_CHR + 1);
  localparam int CHR_CNT_W    = $clog2(NUM_CHARS);

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_PAD  = 2'b11;

  localparam logic [CHAR_W-1:0] CHAR_INVALID = {SYMS_PER_CHR{SYM_PAD}};

  typedef enum logic {
    ST_EMPTY,
    ST_OPEN
  } state_e;

endpackage

// File: rtl/morse_char_assembler.sv
// Single-character shift register with symbol count and overflow flag.
// Outputs reflect this cycle's symbol so a same-cycle commit includes it.
module morse_char_assembler
  import morse_sequence_storage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_i,
  input  logic              dot_i,
  input  logic              dash_i,
  input  logic              clear_i,
  output logic [CHAR_W-1:0] code_o,
  output logic              open_o,
  output logic              ovf_o
);

  logic [CHAR_W-1:0]    code_q, code_d;
  logic [SYM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 sym_v, full, add;

  always_comb begin
    sym_v  = dot_i ^ dash_i;
    full   = (cnt_q == SYM_CNT_W'(SYMS_PER_CHR));
    add    = sym_v & ~full;
    code_d = code_q;
    for (int i = 0; i < SYMS_PER_CHR; i++) begin
      if (add && cnt_q == SYM_CNT_W'(i)) begin
        code_d[CHAR_W-1-2*i -: 2] = dash_i ? SYM_DASH : SYM_DOT;
      end
    end
    cnt_d = cnt_q + SYM_CNT_W'(add);
    // both pulses at once, or a sixth symbol, poison the character
    ovf_d = ovf_q | (dot_i & dash_i) | (sym_v & full);
  end

  assign code_o = code_d;
  assign ovf_o  = ovf_d;
  assign open_o = (cnt_d != '0) | ovf_d;

  always_ff @(posedge clk) begin
    if (reset_i || clear_i) begin
      code_q <= CHAR_INVALID;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/morse_sequence_storage.sv
// Collects committed Morse characters into a 3-slot word and emits it
// with a one-cycle strobe on auto-fill or send.
module morse_sequence_storage
  import morse_sequence_storage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dot_in,
  input  logic                 dash_in,
  input  logic                 char_end,
  input  logic                 send,
  output logic [SEQ_W-1:0]     sequences,
  output logic                 storage_sent,
  output logic                 overflow_err,
  output logic [CHR_CNT_W-1:0] char_count
);

  typedef logic [NUM_CHARS-1:0][CHAR_W-1:0] slots_t;

  state_e               state_q, state_d;
  slots_t               slots_q, slots_d;
  logic [CHR_CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 sent_q, sent_d;
  logic                 ovf_err_q, ovf_err_d;

  logic [CHAR_W-1:0] asm_code;
  logic              asm_open, asm_ovf;
  logic              open_now, commit, emit;

  morse_char_assembler u_asm (
    .clk     (clk),
    .reset_i (reset),
    .dot_i   (dot_in),
    .dash_i  (dash_in),
    .clear_i (commit),
    .code_o  (asm_code),
    .open_o  (asm_open),
    .ovf_o   (asm_ovf)
  );

  always_comb begin
    open_now  = (state_q == ST_OPEN) | asm_open;
    commit    = (char_end | send) & open_now;
    slots_d   = slots_q;
    count_d   = count_q + CHR_CNT_W'(commit);
    state_d   = state_q;
    seq_d     = seq_q;
    ovf_err_d = commit & asm_ovf;
    if (commit) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (count_q == CHR_CNT_W'(i)) begin
          slots_d[i] = asm_ovf ? CHAR_INVALID : asm_code;
        end
      end
      state_d = ST_EMPTY;
    end else if (asm_open) begin
      state_d = ST_OPEN;
    end
    emit   = send |
             (commit & (count_q == CHR_CNT_W'(NUM_CHARS - 1)));
    sent_d = emit;
    // slot 0 lands in the most significant field
    if (emit) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        seq_d[SEQ_W-1-CHAR_W*i -: CHAR_W] = slots_d[i];
      end
      slots_d = '1;
      count_d = '0;
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      slots_q   <= '1;
      count_q   <= '0;
      seq_q     <= '1;
      sent_q    <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slots_q   <= slots_d;
      count_q   <= count_d;
      seq_q     <= seq_d;
      sent_q    <= sent_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign sequences    = seq_q;
  assign storage_sent = sent_q;
  assign overflow_err = ovf_err_q;
  assign char_count   = count_q;

endmodule

// File: tb/tb_morse_sequence_storage.sv
// Testbench for morse_sequence_storage: directed vector table,
// hand-written reset sequence and random traffic against a queue model.
module tb_morse_sequence_storage;

  logic        clk = 1'b0;
  logic        reset, dot_in, dash_in, char_end, send;
  logic [29:0] sequences;
  logic        storage_sent, overflow_err;
  logic [1:0]  char_count;

  int checks   = 0;
  int failures = 0;

  morse_sequence_storage dut (
    .clk          (clk),
    .reset        (reset),
    .dot_in       (dot_in),
    .dash_in      (dash_in),
    .char_end     (char_end),
    .send         (send),
    .sequences    (sequences),
    .storage_sent (storage_sent),
    .overflow_err (overflow_err),
    .char_count   (char_count)
  );

  always #5 clk = ~clk;

  // Reference model: symbols of the open char and committed chars as queues
  logic [1:0]  m_syms[$];
  logic [9:0]  m_chars[$];
  bit          m_inval, m_open, m_sent, m_ovf;
  logic [29:0] m_seq;
  int          m_cnt;

  function automatic logic [9:0] enc(input logic [1:0] syms[$]);
    logic [9:0] c = '0;
    for (int i = 0; i < 5; i++)
      c = {c[7:0], (i < syms.size()) ? syms[i] : 2'b11};
    return c;
  endfunction

  task automatic model_step(input bit d, a, ce, s, r);
    if (r) begin
      m_syms.delete(); m_chars.delete();
      m_inval = 0; m_open = 0; m_sent = 0; m_ovf = 0;
      m_seq = 30'h3FFF_FFFF; m_cnt = 0;
      return;
    end
    m_sent = 0; m_ovf = 0;
    if (d && a) begin
      m_inval = 1; m_open = 1;
    end else if (d || a) begin
      m_open = 1;
      if (m_syms.size() < 5) m_syms.push_back(a ? 2'b01 : 2'b00);
      else m_inval = 1;
    end
    if ((ce || s) && m_open) begin
      m_chars.push_back(m_inval ? 10'h3FF : enc(m_syms));
      m_ovf = m_inval;
      m_syms.delete(); m_inval = 0; m_open = 0;
    end
    if (s || m_chars.size() == 3) begin
      m_seq = 30'h3FFF_FFFF;
      for (int i = 0; i < m_chars.size(); i++)
        m_seq[29-10*i -: 10] = m_chars[i];
      m_sent = 1;
      m_chars.delete();
    end
    m_cnt = m_chars.size();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit d, a, ce, s, r);
    dot_in = d; dash_in = a; char_end = ce; send = s; reset = r;
    @(posedge clk);
    model_step(d, a, ce, s, r);
    #1;
    chk("model_seq", {2'b0, sequences}, {2'b0, m_seq});
    chk("model_sent", {31'b0, storage_sent}, {31'b0, m_sent});
    chk("model_ovf", {31'b0, overflow_err}, {31'b0, m_ovf});
    chk("model_cnt", {30'b0, char_count}, 32'(m_cnt));
  endtask

  typedef struct {
    bit d, a, ce, s;
    logic [29:0] seq;
    bit sent, ovf;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input bit d, a, ce, s, input logic [29:0] sq,
                   input bit st, ov, input int cn, input int rep = 1);
    vec_t e;
    e.d = d; e.a = a; e.ce = ce; e.s = s;
    e.seq = sq; e.sent = st; e.ovf = ov; e.cnt = cn;
    for (int i = 0; i < rep; i++) tbl.push_back(e);
  endtask

  localparam logic [29:0] E = 30'h3FFF_FFFF;

  initial begin
    // SOS
    v(1,0,0,0, E,0,0,0, 3);
    v(0,0,1,0, E,0,0,1);
    v(0,1,0,0, E,0,0,1, 3);
    v(0,0,1,0, E,0,0,2);
    v(1,0,0,0, E,0,0,2, 3);
    v(0,0,1,0, 30'h00F57C0F,1,0,0);
    v(0,0,0,0, 30'h00F57C0F,0,0,0);
    // "O" then send
    v(0,1,0,0, 30'h00F57C0F,0,0,0, 3);
    v(0,0,0,1, 30'h15FFFFFF,1,0,0);
    v(0,0,0,0, 30'h15FFFFFF,0,0,0);
    // six dots overflow
    v(1,0,0,0, 30'h15FFFFFF,0,0,0, 6);
    v(0,0,1,0, 30'h15FFFFFF,0,1,1);
    v(0,0,0,0, 30'h15FFFFFF,0,0,1);
    v(0,0,0,1, E,1,0,0);
    // dash+char_end, dot&dash, dot+send
    v(0,1,0,0, E,0,0,0, 2);
    v(0,1,1,0, E,0,0,1);
    v(1,1,0,0, E,0,0,1);
    v(0,0,1,0, E,0,1,2);
    v(1,0,0,1, 30'h15FFFCFF,1,0,0);
    // idle char_end, empty sends back to back
    v(0,0,1,0, 30'h15FFFCFF,0,0,0);
    v(0,0,0,1, E,1,0,0, 2);
    v(0,0,0,0, E,0,0,0);
    // auto emit, then symbol right after goes to fresh slot 0
    v(1,0,0,0, E,0,0,0);
    v(0,0,1,0, E,0,0,1);
    v(0,1,0,0, E,0,0,1);
    v(0,0,1,0, E,0,0,2);
    v(1,0,1,0, 30'h0FF7FCFF,1,0,0);
    v(0,1,0,1, 30'h1FFFFFFF,1,0,0);
    v(0,0,0,0, 30'h1FFFFFFF,0,0,0);

    cyc(0,0,0,0,1);
    cyc(0,0,0,0,1);
    chk("rst_seq", {2'b0, sequences}, 32'h3FFF_FFFF);
    chk("rst_sent", {31'b0, storage_sent}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_err}, 32'd0);
    chk("rst_cnt", {30'b0, char_count}, 32'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].d, tbl[i].a, tbl[i].ce, tbl[i].s, 0);
      chk($sformatf("tbl%0d_seq", i), {2'b0, sequences}, {2'b0, tbl[i].seq});
      chk($sformatf("tbl%0d_sent", i), {31'b0, storage_sent}, {31'b0, tbl[i].sent});
      chk($sformatf("tbl%0d_ovf", i), {31'b0, overflow_err}, {31'b0, tbl[i].ovf});
      chk($sformatf("tbl%0d_cnt", i), {30'b0, char_count}, 32'(tbl[i].cnt));
    end

    // reset mid-character discards the partial char
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    cyc(0,0,0,0,1);
    chk("rmid_seq", {2'b0, sequences}, 32'h3FFF_FFFF);
    chk("rmid_sent", {31'b0, storage_sent}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0,1,0,0,0);
      chk("rmid_nostrobe", {31'b0, storage_sent}, 32'd0);
    end
    cyc(0,0,0,1,0);
    chk("rmid_word", {2'b0, sequences}, 32'h15FF_FFFF);
    chk("rmid_strobe", {31'b0, storage_sent}, 32'd1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bit d, a, ce, s, r;
      d  = ($urandom_range(0, 99) < 30);
      a  = ($urandom_range(0, 99) < 30);
      ce = ($urandom_range(0, 99) < 15);
      s  = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 199) == 0);
      cyc(d, a, ce, s, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
